pp_frame_sched: RTL and testbench

Frame-level controller for the pre-processing pipeline. Accepts one frame's image dimensions per handshake, range-checks them, and broadcasts latched dimensions plus halved input dimensions to the dataflow stages. It issues `ap_start`-style starts to `NUM_STAGES` downstream processes, collects their done flags, and releases them with a common continue once every stage finishes. It sits between the AXI-Lite control register file and the stage processes, and owns the per-frame start/done/continue sequencing.

---
 rtl/pp_frame_sched_pkg.sv | 33 +++
 rtl/pp_frame_sched_if.sv | 39 +++
 rtl/pp_stage_hs.sv | 42 ++++
 rtl/pp_frame_sched.sv | 163 ++++++++++++++++
 tb/tb_pp_frame_sched.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pp_frame_sched_pkg.sv
// Shared types and constants for the pre-processing frame scheduler.
// Holds the FSM state encoding, error codes, default dimension limits and the dimension range check.
package pp_frame_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_START,
      ST_RUN,
      ST_DONE,
      ST_ERR
   } state_e;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_DIM     = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;

   localparam int DEF_MAX_W = 3840;
   localparam int DEF_MAX_H = 2160;

   // Zero in any dimension, or a width/height beyond the limits, makes the frame unusable.
   function automatic logic dims_legal(input logic [31:0] in_h, input logic [31:0] in_w,
                                       input logic [31:0] out_h, input logic [31:0] out_w,
                                       input int max_w, input int max_h);
      logic nonzero;
      logic in_range;
      nonzero  = (in_h != 32'd0) && (in_w != 32'd0) && (out_h != 32'd0) && (out_w != 32'd0);
      in_range = (in_w <= 32'(max_w)) && (out_w <= 32'(max_w)) &&
                 (in_h <= 32'(max_h)) && (out_h <= 32'(max_h));
      return nonzero && in_range;
   endfunction

endpackage

// File: rtl/pp_frame_sched_if.sv
// Bundle of configuration, stage handshake and status signals around the frame scheduler.
// The slave modport is the scheduler's view; the master modport is the surrounding system's view.
interface pp_frame_sched_if #(
   parameter int NUM_STAGES = 4
);
   logic                  cfg_valid;
   logic                  cfg_ready;
   logic [31:0]           cfg_in_h;
   logic [31:0]           cfg_in_w;
   logic [31:0]           cfg_out_h;
   logic [31:0]           cfg_out_w;
   logic [NUM_STAGES-1:0] stg_start;
   logic [NUM_STAGES-1:0] stg_ready;
   logic [NUM_STAGES-1:0] stg_done;
   logic [NUM_STAGES-1:0] stg_continue;
   logic [31:0]           dim_in_h;
   logic [31:0]           dim_in_w;
   logic [31:0]           dim_out_h;
   logic [31:0]           dim_out_w;
   logic [10:0]           dim_half_h;
   logic [10:0]           dim_half_w;
   logic                  busy;
   logic                  frame_done;
   logic                  err;
   logic [1:0]            err_code;
   logic [15:0]           frame_cnt;

   modport slave (
      input  cfg_valid, cfg_in_h, cfg_in_w, cfg_out_h, cfg_out_w, stg_ready, stg_done,
      output cfg_ready, stg_start, stg_continue, dim_in_h, dim_in_w, dim_out_h, dim_out_w,
             dim_half_h, dim_half_w, busy, frame_done, err, err_code, frame_cnt
   );

   modport master (
      output cfg_valid, cfg_in_h, cfg_in_w, cfg_out_h, cfg_out_w, stg_ready, stg_done,
      input  cfg_ready, stg_start, stg_continue, dim_in_h, dim_in_w, dim_out_h, dim_out_w,
             dim_half_h, dim_half_w, busy, frame_done, err, err_code, frame_cnt
   );
endinterface

// File: rtl/pp_stage_hs.sv
// Per-stage start/done bookkeeping: raises start until the stage accepts it and remembers done.
// The *_nx outputs include this cycle's events so the controller can move on without an extra cycle.
module pp_stage_hs (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic start_en_i,
   input  logic track_en_i,
   input  logic clr_i,
   input  logic stg_ready_i,
   input  logic stg_done_i,
   output logic stg_start_o,
   output logic started_nx_o,
   output logic done_nx_o
);

   logic started_q, started_d;
   logic done_q, done_d;

   assign stg_start_o  = start_en_i & ~started_q;
   assign started_nx_o = started_q | (stg_start_o & stg_ready_i);
   assign done_nx_o    = done_q | (track_en_i & stg_done_i);

   always_comb begin
      started_d = started_nx_o;
      done_d    = done_nx_o;
      if (clr_i) begin
         started_d = 1'b0;
         done_d    = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         started_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         started_q <= started_d;
         done_q    <= done_d;
      end
   end

endmodule

// File: rtl/pp_frame_sched.sv
// Frame scheduler: accepts and range-checks frame dimensions, then sequences start/done/continue
// across NUM_STAGES processes. Optional watchdog enabled by defining PP_FRAME_SCHED_TIMEOUT_EN.
module pp_frame_sched
   import pp_frame_sched_pkg::*;
#(
   parameter int NUM_STAGES = 4,
   parameter int MAX_W      = DEF_MAX_W,
   parameter int MAX_H      = DEF_MAX_H,
   parameter int TO_W       = 24
) (
   input  logic            ap_clk,
   input  logic            ap_rst_n,
   pp_frame_sched_if.slave ctl
);

   state_e                state_q, state_d;
   logic                  err_q, err_d;
   logic [1:0]            code_q, code_d;
   logic [15:0]           cnt_q, cnt_d;
   logic [31:0]           in_h_q, in_w_q, out_h_q, out_w_q;
   logic                  accept, in_start, in_track, clr_masks, legal, timeout;
   logic [NUM_STAGES-1:0] start_vec, started_nx, done_nx;

   assign accept    = (state_q == ST_IDLE) & ctl.cfg_valid;
   assign in_start  = (state_q == ST_START);
   assign in_track  = in_start | (state_q == ST_RUN);
   assign clr_masks = (state_q == ST_DONE) | (state_q == ST_ERR);
   assign legal     = dims_legal(in_h_q, in_w_q, out_h_q, out_w_q, MAX_W, MAX_H);

   for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
      pp_stage_hs u_hs (
         .clk_i        (ap_clk),
         .rst_ni       (ap_rst_n),
         .start_en_i   (in_start),
         .track_en_i   (in_track),
         .clr_i        (clr_masks),
         .stg_ready_i  (ctl.stg_ready[i]),
         .stg_done_i   (ctl.stg_done[i]),
         .stg_start_o  (start_vec[i]),
         .started_nx_o (started_nx[i]),
         .done_nx_o    (done_nx[i])
      );
   end

`ifdef PP_FRAME_SCHED_TIMEOUT_EN
   // Fires on the cycle the counter reads 2^TO_W-2, so ERR is entered 2^TO_W-1 cycles after START.
   localparam logic [TO_W-1:0] WDOG_LAST = ~TO_W'(1);
   logic [TO_W-1:0] wdog_q, wdog_d;

   always_comb begin
      wdog_d = wdog_q;
      if (state_q == ST_CHECK) begin
         wdog_d = '0;
      end else if (in_track) begin
         wdog_d = wdog_q + 1'b1;
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) wdog_q <= '0;
      else           wdog_q <= wdog_d;
   end

   assign timeout = in_track & (wdog_q == WDOG_LAST);
`else
   logic unused_to_w;
   assign timeout     = 1'b0;
   assign unused_to_w = (TO_W != 0);
`endif

   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      code_d  = code_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_CHECK;
               err_d   = 1'b0;
               code_d  = ERR_NONE;
            end
         end
         ST_CHECK: begin
            if (legal) begin
               state_d = ST_START;
            end else begin
               state_d = ST_ERR;
               err_d   = 1'b1;
               code_d  = ERR_DIM;
            end
         end
         ST_START: begin
            if (timeout) begin
               state_d = ST_ERR;
               err_d   = 1'b1;
               code_d  = ERR_TIMEOUT;
            end else if (&started_nx) begin
               state_d = ST_RUN;
            end
         end
         // A frame that completes on the watchdog's last cycle is still treated as completed.
         ST_RUN: begin
            if (&done_nx) begin
               state_d = ST_DONE;
            end else if (timeout) begin
               state_d = ST_ERR;
               err_d   = 1'b1;
               code_d  = ERR_TIMEOUT;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            cnt_d   = cnt_q + 16'd1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q <= ST_IDLE;
         err_q   <= 1'b0;
         code_q  <= ERR_NONE;
         cnt_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         code_q  <= code_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         in_h_q  <= 32'd0;
         in_w_q  <= 32'd0;
         out_h_q <= 32'd0;
         out_w_q <= 32'd0;
      end else if (accept) begin
         in_h_q  <= ctl.cfg_in_h;
         in_w_q  <= ctl.cfg_in_w;
         out_h_q <= ctl.cfg_out_h;
         out_w_q <= ctl.cfg_out_w;
      end
   end

   assign ctl.cfg_ready    = (state_q == ST_IDLE);
   assign ctl.busy         = (state_q != ST_IDLE);
   assign ctl.stg_start    = start_vec;
   assign ctl.stg_continue = {NUM_STAGES{state_q == ST_DONE}};
   assign ctl.frame_done   = (state_q == ST_DONE);
   assign ctl.err          = err_q;
   assign ctl.err_code     = code_q;
   assign ctl.frame_cnt    = cnt_q;
   assign ctl.dim_in_h     = in_h_q;
   assign ctl.dim_in_w     = in_w_q;
   assign ctl.dim_out_h    = out_h_q;
   assign ctl.dim_out_w    = out_w_q;
   assign ctl.dim_half_h   = in_h_q[11:1];
   assign ctl.dim_half_w   = in_w_q[11:1];

endmodule

// File: tb/tb_pp_frame_sched.sv
// Bench for pp_frame_sched: directed and randomized frames checked against a cycle-count model
// derived from the frame rules (start window per stage, completion cycle from last accept/done).
module tb_pp_frame_sched;
   localparam int NS = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          checks = 0;
   int          errors = 0;
   logic [15:0] cnt_model = 16'd0;

   pp_frame_sched_if #(.NUM_STAGES(NS)) bus ();

   pp_frame_sched #(.NUM_STAGES(NS), .MAX_W(3840), .MAX_H(2160), .TO_W(4)) dut (
      .ap_clk   (clk),
      .ap_rst_n (rst_n),
      .ctl      (bus)
   );

   always #5 clk = ~clk;

   function automatic bit legal_dims(input logic [31:0] ih, input logic [31:0] iw,
                                     input logic [31:0] oh, input logic [31:0] ow);
      if (ih == 0 || iw == 0 || oh == 0 || ow == 0) return 1'b0;
      if (iw > 3840 || ow > 3840) return 1'b0;
      if (ih > 2160 || oh > 2160) return 1'b0;
      return 1'b1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.cfg_valid = 1'b0;
      bus.stg_ready = '0;
      bus.stg_done  = '0;
   endtask

   // Runs one frame. rd[i]: cycles stage i holds off ready after start begins (rel. cycle 2);
   // dd[i]: relative cycle of stage i's done pulse (>= 2). Ends in the first IDLE cycle.
   task automatic run_frame(input logic [31:0] ih, input logic [31:0] iw, input logic [31:0] oh,
                            input logic [31:0] ow, input int rd[NS], input int dd[NS],
                            output int waited);
      bit          ok;
      int          dn, amax, dmax;
      logic [NS-1:0] exp_start, exp_cont;
      logic [15:0] exp_cnt;
      logic        exp_busy, exp_rdy, exp_fd, exp_err;
      logic [1:0]  exp_code;
      waited = 0;
      while (bus.cfg_ready !== 1'b1 && waited < 50) begin
         tick();
         waited++;
      end
      checks++;
      if (bus.cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL cfg_ready_wait: cfg_ready=%b after %0d cycles, required 1", bus.cfg_ready, waited);
         return;
      end
      bus.cfg_valid = 1'b1;
      bus.cfg_in_h = ih; bus.cfg_in_w = iw; bus.cfg_out_h = oh; bus.cfg_out_w = ow;
      bus.stg_ready = '0;
      bus.stg_done  = '0;
      ok = legal_dims(ih, iw, oh, ow);
      amax = 0; dmax = 0;
      for (int i = 0; i < NS; i++) begin
         if (2 + rd[i] > amax) amax = 2 + rd[i];
         if (dd[i] > dmax) dmax = dd[i];
      end
      // Completion: one cycle after RUN begins (last accept + 1) or after the last done, whichever later.
      dn = ok ? ((amax + 2 > dmax + 1) ? amax + 2 : dmax + 1) : 2;
      for (int k = 1; k <= dn + 1; k++) begin
         tick();
         for (int i = 0; i < NS; i++) exp_start[i] = ok && k >= 2 && k <= 2 + rd[i];
         exp_cont = (ok && k == dn) ? '1 : '0;
         exp_fd   = ok && k == dn;
         exp_busy = k <= dn;
         exp_rdy  = k == dn + 1;
         exp_err  = !ok && k >= 2;
         exp_code = (!ok && k >= 2) ? 2'd1 : 2'd0;
         exp_cnt  = (ok && k == dn + 1) ? cnt_model + 16'd1 : cnt_model;
         checks++; if (bus.cfg_ready !== exp_rdy) begin errors++; $display("FAIL cfg_ready k=%0d: got %b required %b", k, bus.cfg_ready, exp_rdy); end
         checks++; if (bus.busy !== exp_busy) begin errors++; $display("FAIL busy k=%0d: got %b required %b", k, bus.busy, exp_busy); end
         checks++; if (bus.stg_start !== exp_start) begin errors++; $display("FAIL stg_start k=%0d: got %b required %b", k, bus.stg_start, exp_start); end
         checks++; if (bus.stg_continue !== exp_cont) begin errors++; $display("FAIL stg_continue k=%0d: got %b required %b", k, bus.stg_continue, exp_cont); end
         checks++; if (bus.frame_done !== exp_fd) begin errors++; $display("FAIL frame_done k=%0d: got %b required %b", k, bus.frame_done, exp_fd); end
         checks++; if (bus.err !== exp_err) begin errors++; $display("FAIL err k=%0d: got %b required %b", k, bus.err, exp_err); end
         checks++; if (bus.err_code !== exp_code) begin errors++; $display("FAIL err_code k=%0d: got %0d required %0d", k, bus.err_code, exp_code); end
         checks++; if (bus.frame_cnt !== exp_cnt) begin errors++; $display("FAIL frame_cnt k=%0d: got %0d required %0d", k, bus.frame_cnt, exp_cnt); end
         checks++; if ({bus.dim_in_h, bus.dim_in_w, bus.dim_out_h, bus.dim_out_w} !== {ih, iw, oh, ow}) begin
            errors++; $display("FAIL dims k=%0d: got %0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d", k,
                               bus.dim_in_h, bus.dim_in_w, bus.dim_out_h, bus.dim_out_w, ih, iw, oh, ow); end
         checks++; if ({bus.dim_half_h, bus.dim_half_w} !== {ih[11:1], iw[11:1]}) begin
            errors++; $display("FAIL dim_half k=%0d: got %0d/%0d required %0d/%0d", k, bus.dim_half_h, bus.dim_half_w, ih[11:1], iw[11:1]); end
         // Inputs for this cycle; cfg noise while busy must be ignored, done noise in CHECK/DONE too.
         if (k <= dn) begin
            bus.cfg_valid = 1'($urandom_range(0, 1));
            bus.cfg_in_h = $urandom; bus.cfg_in_w = $urandom; bus.cfg_out_h = $urandom; bus.cfg_out_w = $urandom;
         end else begin
            bus.cfg_valid = 1'b0;
         end
         for (int i = 0; i < NS; i++) begin
            bus.stg_ready[i] = (k == 1) ? 1'($urandom_range(0, 1)) : (k >= 2 + rd[i]);
            bus.stg_done[i]  = (k == 1 || k == dn) ? 1'($urandom_range(0, 1)) : (k == dd[i]);
         end
      end
      if (ok) cnt_model = cnt_model + 16'd1;
   endtask

   task automatic test_reset();
      idle_inputs();
      bus.cfg_in_h = '0; bus.cfg_in_w = '0; bus.cfg_out_h = '0; bus.cfg_out_w = '0;
      rst_n = 1'b0;
      tick(); tick();
      checks++; if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b required 1", bus.cfg_ready); end
      checks++; if ({bus.busy, bus.frame_done, bus.err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b required 000", {bus.busy, bus.frame_done, bus.err}); end
      checks++; if ({bus.stg_start, bus.stg_continue} !== '0) begin errors++; $display("FAIL reset_stage: got %b/%b required 0/0", bus.stg_start, bus.stg_continue); end
      checks++; if ({bus.err_code, bus.frame_cnt} !== 18'd0) begin errors++; $display("FAIL reset_code_cnt: got %0d/%0d required 0/0", bus.err_code, bus.frame_cnt); end
      checks++; if ({bus.dim_in_h, bus.dim_in_w, bus.dim_out_h, bus.dim_out_w, bus.dim_half_h, bus.dim_half_w} !== '0) begin
         errors++; $display("FAIL reset_dims: got %0d/%0d/%0d/%0d required all 0", bus.dim_in_h, bus.dim_in_w, bus.dim_out_h, bus.dim_out_w); end
      rst_n = 1'b1;
      tick();
      checks++; if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b required 1", bus.cfg_ready); end
      cnt_model = 16'd0;
   endtask

   task automatic test_basic();
      int rd[NS]; int dd[NS]; int w;
      rd = '{0, 0, 0, 0};
      dd = '{10, 11, 12, 13};
      run_frame(32'd1080, 32'd1920, 32'd720, 32'd1280, rd, dd, w);
      checks++; if ({bus.dim_half_h, bus.dim_half_w} !== {11'd540, 11'd960}) begin errors++; $display("FAIL basic_half: got %0d/%0d required 540/960", bus.dim_half_h, bus.dim_half_w); end
      checks++; if (bus.frame_cnt !== 16'd1) begin errors++; $display("FAIL basic_cnt: got %0d required 1", bus.frame_cnt); end
   endtask

   task automatic test_stagger();
      int rd[NS]; int dd[NS]; int w;
      rd = '{0, 0, 5, 0};
      dd = '{9, 9, 10, 12};
      run_frame(32'd720, 32'd1280, 32'd360, 32'd640, rd, dd, w);
   endtask

   task automatic test_bad_dims();
      int rd[NS]; int dd[NS]; int w;
      rd = '{0, 0, 0, 0};
      dd = '{3, 4, 5, 6};
      run_frame(32'd1080, 32'd4000, 32'd720, 32'd1280, rd, dd, w);
      run_frame(32'd2160, 32'd3840, 32'd2160, 32'd3840, rd, dd, w);
      run_frame(32'd2161, 32'd3840, 32'd2160, 32'd3840, rd, dd, w);
      run_frame(32'd2160, 32'd3840, 32'd2160, 32'd3841, rd, dd, w);
      run_frame(32'd0, 32'd100, 32'd100, 32'd100, rd, dd, w);
      run_frame(32'd100, 32'd100, 32'd100, 32'd100, rd, dd, w);
   endtask

   task automatic test_done_with_ready();
      int rd[NS]; int dd[NS]; int w;
      rd = '{1, 2, 3, 0};
      dd = '{3, 6, 8, 9};
      run_frame(32'd480, 32'd640, 32'd240, 32'd320, rd, dd, w);
   endtask

   task automatic test_back_to_back();
      int rd[NS]; int dd[NS]; int w;
      rd = '{0, 0, 0, 0};
      dd = '{2, 2, 2, 2};
      for (int f = 0; f < 3; f++) begin
         run_frame(32'd64 + 32'(f), 32'd128, 32'd32, 32'd64, rd, dd, w);
         checks++; if (w != 0) begin errors++; $display("FAIL back_to_back_gap f=%0d: waited %0d extra cycles, required 0", f, w); end
      end
   endtask

   task automatic test_random();
      int rd[NS]; int dd[NS]; int w;
      logic [31:0] ih, iw, oh, ow;
      for (int f = 0; f < 25; f++) begin
         ih = $urandom_range(1, 2160); iw = $urandom_range(1, 3840);
         oh = $urandom_range(1, 2160); ow = $urandom_range(1, 3840);
         case ($urandom_range(0, 9))
            0: iw = $urandom_range(3841, 9000);
            1: oh = $urandom_range(2161, 5000);
            2: ow = 32'd0;
            3: ih = 32'hFFFF_FFFF;
            4: begin iw = 32'd3840; oh = 32'd2160; end
            default: ;
         endcase
         for (int i = 0; i < NS; i++) begin
            rd[i] = $urandom_range(0, 4);
            dd[i] = $urandom_range(2, 12);
         end
         run_frame(ih, iw, oh, ow, rd, dd, w);
      end
   endtask

   task automatic test_stall();
      int w;
      w = 0;
      while (bus.cfg_ready !== 1'b1 && w < 50) begin tick(); w++; end
      bus.cfg_valid = 1'b1;
      bus.cfg_in_h = 32'd100; bus.cfg_in_w = 32'd200; bus.cfg_out_h = 32'd50; bus.cfg_out_w = 32'd100;
      bus.stg_ready = '0; bus.stg_done = '0;
`ifdef PP_FRAME_SCHED_TIMEOUT_EN
      // START entered at rel. cycle 2; watchdog (TO_W=4) forces ERR 15 cycles later.
      for (int k = 1; k <= 18; k++) begin
         tick();
         checks++; if (bus.busy !== (k <= 17)) begin errors++; $display("FAIL to_busy k=%0d: got %b required %b", k, bus.busy, k <= 17); end
         checks++; if (bus.err !== (k >= 17)) begin errors++; $display("FAIL to_err k=%0d: got %b required %b", k, bus.err, k >= 17); end
         checks++; if (bus.err_code !== ((k >= 17) ? 2'd2 : 2'd0)) begin errors++; $display("FAIL to_code k=%0d: got %0d required %0d", k, bus.err_code, (k >= 17) ? 2 : 0); end
         checks++; if (bus.stg_continue !== '0) begin errors++; $display("FAIL to_continue k=%0d: got %b required 0", k, bus.stg_continue); end
         checks++; if (bus.frame_cnt !== cnt_model) begin errors++; $display("FAIL to_cnt k=%0d: got %0d required %0d", k, bus.frame_cnt, cnt_model); end
         bus.cfg_valid = 1'b0;
         bus.stg_ready = '1;
         bus.stg_done  = (k == 4) ? 4'b0111 : 4'b0000;
      end
      checks++; if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL to_ready: got %b required 1", bus.cfg_ready); end
`else
      // Without the watchdog, a missing done keeps the frame in RUN until reset.
      for (int k = 1; k <= 40; k++) begin
         tick();
         checks++; if (bus.busy !== (k >= 1)) begin errors++; $display("FAIL stall_busy k=%0d: got %b required 1", k, bus.busy); end
         checks++; if ({bus.stg_continue, bus.frame_done, bus.err} !== '0) begin errors++; $display("FAIL stall_out k=%0d: got %b/%b/%b required 0", k, bus.stg_continue, bus.frame_done, bus.err); end
         bus.cfg_valid = 1'b0;
         bus.stg_ready = '1;
         bus.stg_done  = (k == 4) ? 4'b0111 : 4'b0000;
      end
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({bus.busy, bus.stg_start} !== '0) begin errors++; $display("FAIL stall_rst_async: got busy=%b start=%b required 0/0", bus.busy, bus.stg_start); end
      checks++; if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL stall_rst_ready: got %b required 1", bus.cfg_ready); end
      idle_inputs();
      tick();
      rst_n = 1'b1;
      tick();
      checks++; if (bus.frame_cnt !== 16'd0) begin errors++; $display("FAIL stall_rst_cnt: got %0d required 0", bus.frame_cnt); end
      cnt_model = 16'd0;
`endif
   endtask

   task automatic test_reset_mid_frame();
      int w;
      w = 0;
      while (bus.cfg_ready !== 1'b1 && w < 50) begin tick(); w++; end
      checks++; if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL rmf_wait: cfg_ready=%b required 1", bus.cfg_ready); end
      bus.cfg_valid = 1'b1;
      bus.cfg_in_h = 32'd300; bus.cfg_in_w = 32'd400; bus.cfg_out_h = 32'd150; bus.cfg_out_w = 32'd200;
      bus.stg_ready = '0; bus.stg_done = '0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         bus.cfg_valid = 1'b0;
         bus.stg_ready = (k >= 2) ? 4'b1011 : 4'b0000;
      end
      checks++; if (bus.stg_start !== 4'b0100) begin errors++; $display("FAIL rmf_pending_start: got %b required 0100", bus.stg_start); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({bus.busy, bus.stg_start, bus.stg_continue} !== '0) begin
         errors++; $display("FAIL rmf_async_drop: got busy=%b start=%b cont=%b required all 0", bus.busy, bus.stg_start, bus.stg_continue); end
      idle_inputs();
      tick();
      rst_n = 1'b1;
      tick();
      checks++; if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL rmf_ready: got %b required 1", bus.cfg_ready); end
      checks++; if ({bus.frame_cnt, bus.err, bus.dim_in_h} !== '0) begin
         errors++; $display("FAIL rmf_cleared: got cnt=%0d err=%b in_h=%0d required 0/0/0", bus.frame_cnt, bus.err, bus.dim_in_h); end
      cnt_model = 16'd0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stagger();
      test_bad_dims();
      test_done_with_ready();
      test_back_to_back();
      test_random();
      test_stall();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish within the time limit");
      $fatal(1);
   end

endmodule
